// File: rtl/card_game_pkg.sv
// Shared types and helpers for the N-player card game controller.
// Holds the FSM state encoding, LFSR taps and the card mapping.
package card_game_pkg;

    typedef enum logic [2:0] {
        IDLE,
        DEAL,
        CHECK,
        WAIT,
        HIT,
        RESULT
    } state_t;

    localparam logic [15:0] LFSR_MASK = 16'hB400;

    function automatic logic [3:0] card_of(
        input logic [15:0] lfsr,
        input int          card_max
    );
        return 4'(lfsr % 16'(card_max)) + 4'd1;
    endfunction

endpackage

// File: rtl/card_game_np_if.sv
// Board-side bundle: qualified button/MORE inputs in, card and result
// strobes out towards the display driver.
interface card_game_np_if #(
    parameter int NUM_PLAYERS = 4,
    parameter int MAX_HAND    = 21,
    parameter int CARD_MAX    = 10
);
    localparam int PID_W = $clog2(NUM_PLAYERS);
    localparam int SUM_W = $clog2(MAX_HAND + CARD_MAX + 1);

    logic                   IN_VALID;
    logic                   BUTTON;
    logic [NUM_PLAYERS-1:0] MORE;
    logic                   OUT_VALID;
    logic [3:0]             CARD;
    logic [PID_W-1:0]       PLAYER;
    logic                   RES_VALID;
    logic [PID_W-1:0]       WIN_ID;
    logic                   TIE;
    logic [SUM_W-1:0]       SUM;

    modport master (
        output IN_VALID, BUTTON, MORE,
        input  OUT_VALID, CARD, PLAYER, RES_VALID, WIN_ID, TIE, SUM
    );

    modport slave (
        input  IN_VALID, BUTTON, MORE,
        output OUT_VALID, CARD, PLAYER, RES_VALID, WIN_ID, TIE, SUM
    );

endinterface

// File: rtl/card_lfsr.sv
// Free-running 16-bit Galois LFSR turned into a card value 1..CARD_MAX.
// Steps every cycle so the deal order depends on when the game starts.
module card_lfsr
    import card_game_pkg::*;
#(
    parameter logic [15:0] SEED     = 16'hACE1,
    parameter int          CARD_MAX = 10
)(
    input  logic       CLK,
    input  logic       RESET,
    output logic [3:0] o_card
);

    logic [15:0] r_lfsr;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_lfsr <= SEED;
        end else begin
            r_lfsr <= (r_lfsr >> 1) ^ (r_lfsr[0] ? LFSR_MASK : 16'h0000);
        end
    end

    assign o_card = card_of(r_lfsr, CARD_MAX);

endmodule

// File: rtl/card_game_np.sv
// N-player blackjack-style controller: deals, serves hit masks,
// eliminates busts and reports the unique highest hand or a tie.
module card_game_np
    import card_game_pkg::*;
#(
    parameter int          NUM_PLAYERS = 4,
    parameter int          MAX_HAND    = 21,
    parameter int          CARD_MAX    = 10,
    parameter logic [15:0] SEED        = 16'hACE1
)(
    input  logic          CLK,
    input  logic          RESET,
    card_game_np_if.slave bus
);

    localparam int PID_W = $clog2(NUM_PLAYERS);
    localparam int SUM_W = $clog2(MAX_HAND + CARD_MAX + 1);

    state_t                 r_state;
    state_t                 w_state_n;
    logic                   r_iv;
    logic                   r_btn;
    logic [NUM_PLAYERS-1:0] r_more;
    logic [SUM_W-1:0]       r_hand [NUM_PLAYERS];
    logic [NUM_PLAYERS-1:0] r_bust;
    logic [NUM_PLAYERS-1:0] r_req;
    logic [PID_W-1:0]       r_p;
    logic                   r_ov;
    logic                   r_rv;
    logic                   r_tie;
    logic [3:0]             r_card;
    logic [PID_W-1:0]       r_player;
    logic [PID_W-1:0]       r_win;
    logic [SUM_W-1:0]       r_sum;

    logic                   w_go;
    logic                   w_last;
    logic [3:0]             w_card;
    logic [SUM_W-1:0]       w_add;
    logic [NUM_PLAYERS-1:0] w_bust_n;
    logic [NUM_PLAYERS-1:0] w_req;
    logic [NUM_PLAYERS-1:0] w_rest;
    logic [PID_W:0]         w_alive;
    logic [PID_W-1:0]       w_low_req;
    logic [PID_W-1:0]       w_low_rest;
    logic [SUM_W-1:0]       w_max;
    logic [PID_W-1:0]       w_win;
    logic [PID_W:0]         w_cnt;
    logic                   w_tie;

    card_lfsr #(
        .SEED     (SEED),
        .CARD_MAX (CARD_MAX)
    ) u_lfsr (
        .CLK    (CLK),
        .RESET  (RESET),
        .o_card (w_card)
    );

    assign w_go   = r_iv & r_btn;
    assign w_last = (r_p == PID_W'(NUM_PLAYERS - 1));
    assign w_add  = r_hand[r_p] + SUM_W'(w_card);
    assign w_req  = r_more & ~r_bust;

    always_comb begin
        w_bust_n   = r_bust;
        w_alive    = '0;
        w_rest     = r_req;
        w_low_req  = '0;
        w_low_rest = '0;
        w_max      = '0;
        w_win      = '0;
        w_cnt      = '0;
        w_rest[r_p] = 1'b0;
        for (int i = 0; i < NUM_PLAYERS; i++) begin
            if (r_hand[i] > SUM_W'(MAX_HAND)) w_bust_n[i] = 1'b1;
            if (!w_bust_n[i]) w_alive = w_alive + 1'b1;
        end
        for (int i = NUM_PLAYERS - 1; i >= 0; i--) begin
            if (w_req[i])  w_low_req  = PID_W'(i);
            if (w_rest[i]) w_low_rest = PID_W'(i);
        end
        // Busts are already folded into r_bust by the time RESULT runs.
        for (int i = 0; i < NUM_PLAYERS; i++) begin
            if (!r_bust[i]) begin
                if (w_cnt == '0 || r_hand[i] > w_max) begin
                    w_max = r_hand[i];
                    w_win = PID_W'(i);
                    w_cnt = (PID_W+1)'(1);
                end else if (r_hand[i] == w_max) begin
                    w_cnt = w_cnt + 1'b1;
                end
            end
        end
        w_tie = (w_cnt != (PID_W+1)'(1));
    end

    always_comb begin
        w_state_n = r_state;
        unique case (r_state)
            IDLE:   if (w_go) w_state_n = DEAL;
            DEAL:   if (w_last) w_state_n = CHECK;
            CHECK:  w_state_n = (w_alive < (PID_W+1)'(2)) ? RESULT : WAIT;
            WAIT:   if (w_go) w_state_n = (w_req == '0) ? RESULT : HIT;
            HIT:    if (w_rest == '0) w_state_n = CHECK;
            RESULT: w_state_n = IDLE;
            default: w_state_n = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) r_state <= IDLE;
        else       r_state <= w_state_n;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_iv     <= 1'b0;
            r_btn    <= 1'b0;
            r_more   <= '0;
            r_bust   <= '0;
            r_req    <= '0;
            r_p      <= '0;
            r_ov     <= 1'b0;
            r_rv     <= 1'b0;
            r_tie    <= 1'b0;
            r_card   <= '0;
            r_player <= '0;
            r_win    <= '0;
            r_sum    <= '0;
            for (int i = 0; i < NUM_PLAYERS; i++) r_hand[i] <= '0;
        end else begin
            r_iv   <= bus.IN_VALID;
            r_btn  <= bus.BUTTON;
            r_more <= bus.MORE;
            r_ov   <= 1'b0;
            r_rv   <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (w_go) begin
                        r_bust <= '0;
                        r_p    <= '0;
                        for (int i = 0; i < NUM_PLAYERS; i++) r_hand[i] <= '0;
                    end
                end
                DEAL: begin
                    r_hand[r_p] <= w_add;
                    r_ov        <= 1'b1;
                    r_card      <= w_card;
                    r_player    <= r_p;
                    if (!w_last) r_p <= r_p + 1'b1;
                end
                CHECK: r_bust <= w_bust_n;
                WAIT: begin
                    if (w_go && w_req != '0) begin
                        r_req <= w_req;
                        r_p   <= w_low_req;
                    end
                end
                HIT: begin
                    r_hand[r_p] <= w_add;
                    r_ov        <= 1'b1;
                    r_card      <= w_card;
                    r_player    <= r_p;
                    r_req       <= w_rest;
                    r_p         <= w_low_rest;
                end
                RESULT: begin
                    r_rv  <= 1'b1;
                    r_tie <= w_tie;
                    r_win <= w_tie ? '0 : w_win;
                    r_sum <= w_tie ? '0 : w_max;
                end
                default: ;
            endcase
        end
    end

    assign bus.OUT_VALID = r_ov;
    assign bus.CARD      = r_card;
    assign bus.PLAYER    = r_player;
    assign bus.RES_VALID = r_rv;
    assign bus.WIN_ID    = r_win;
    assign bus.TIE       = r_tie;
    assign bus.SUM       = r_sum;

endmodule

// File: tb/tb_card_game_np.sv
// Bench: directed 3-player games with unit cards, then random
// 4-player games against a reference model of hands and winner.
module tb_card_game_np;

    localparam logic [15:0] SEED = 16'h5A17;

    logic       CLK   = 1'b0;
    logic       RESET = 1'b1;
    logic       iv    = 1'b0;
    logic       btn   = 1'b0;
    logic       sel   = 1'b0;
    logic [3:0] more  = 4'd0;

    int errs   = 0;
    int checks = 0;
    int cyc    = 0;
    int t_last = 0;
    int t_prev = 0;

    logic [15:0] m_lfsr = SEED;
    int          m_card = 0;

    int obs_ov, obs_card, obs_player, obs_rv, obs_win, obs_tie, obs_sum;

    always #5 CLK = ~CLK;

    card_game_np_if #(.NUM_PLAYERS(3), .MAX_HAND(2), .CARD_MAX(1)) bs ();
    card_game_np_if #(.NUM_PLAYERS(4), .MAX_HAND(21), .CARD_MAX(10)) bb ();

    assign bs.IN_VALID = iv & ~sel;
    assign bs.BUTTON   = btn;
    assign bs.MORE     = more[2:0];
    assign bb.IN_VALID = iv & sel;
    assign bb.BUTTON   = btn;
    assign bb.MORE     = more;

    card_game_np #(
        .NUM_PLAYERS (3),
        .MAX_HAND    (2),
        .CARD_MAX    (1),
        .SEED        (16'hACE1)
    ) u_small (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bs)
    );

    card_game_np #(
        .NUM_PLAYERS (4),
        .MAX_HAND    (21),
        .CARD_MAX    (10),
        .SEED        (SEED)
    ) u_big (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bb)
    );

    always_comb begin
        if (sel) begin
            obs_ov     = int'(bb.OUT_VALID);
            obs_card   = int'(bb.CARD);
            obs_player = int'(bb.PLAYER);
            obs_rv     = int'(bb.RES_VALID);
            obs_win    = int'(bb.WIN_ID);
            obs_tie    = int'(bb.TIE);
            obs_sum    = int'(bb.SUM);
        end else begin
            obs_ov     = int'(bs.OUT_VALID);
            obs_card   = int'(bs.CARD);
            obs_player = int'(bs.PLAYER);
            obs_rv     = int'(bs.RES_VALID);
            obs_win    = int'(bs.WIN_ID);
            obs_tie    = int'(bs.TIE);
            obs_sum    = int'(bs.SUM);
        end
    end

    // Card that the big DUT would deal at this edge, from the pre-edge LFSR.
    always @(posedge CLK) begin
        cyc    = cyc + 1;
        m_card = int'(m_lfsr % 16'd10) + 1;
        if (RESET) m_lfsr = SEED;
        else       m_lfsr = {1'b0, m_lfsr[15:1]} ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
    end

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic press(input logic [3:0] mask);
        @(negedge CLK);
        iv   = 1'b1;
        btn  = 1'b1;
        more = mask;
        @(negedge CLK);
        iv   = 1'b0;
        btn  = 1'b0;
        more = 4'd0;
    endtask

    task automatic wait_evt(output bit ov, output bit rv);
        bit done;
        done = 1'b0;
        ov   = 1'b0;
        rv   = 1'b0;
        for (int n = 0; n < 24 && !done; n++) begin
            @(negedge CLK);
            if (obs_ov != 0 || obs_rv != 0) begin
                ov   = (obs_ov != 0);
                rv   = (obs_rv != 0);
                done = 1'b1;
                chk("exclusive", int'(ov & rv), 0);
            end
        end
    endtask

    task automatic expect_deal(input int p, input bit mdl, output int c);
        bit ov, rv;
        wait_evt(ov, rv);
        c = mdl ? m_card : 1;
        chk("deal_valid", int'(ov), 1);
        if (ov) begin
            t_prev = t_last;
            t_last = cyc;
            chk("player", obs_player, p);
            chk("card", obs_card, c);
            if (mdl) chk("card_range", int'(obs_card >= 1 && obs_card <= 10), 1);
        end
    endtask

    task automatic expect_res(input int w, input int t, input int s);
        bit ov, rv;
        wait_evt(ov, rv);
        chk("res_valid", int'(rv), 1);
        if (rv) begin
            chk("win_id", obs_win, w);
            chk("tie", obs_tie, t);
            chk("sum", obs_sum, s);
        end
    endtask

    task automatic deal3();
        int c;
        for (int p = 0; p < 3; p++) expect_deal(p, 1'b0, c);
    endtask

    task automatic big_game();
        int          hand [4];
        bit    [3:0] bust;
        logic  [3:0] mask;
        logic  [3:0] req;
        int          c, alive, best, win, cnt;
        bust = 4'd0;
        for (int i = 0; i < 4; i++) hand[i] = 0;
        press(4'($urandom_range(0, 15)));
        for (int p = 0; p < 4; p++) begin
            expect_deal(p, 1'b1, c);
            hand[p] += c;
        end
        for (int r = 0; r < 40; r++) begin
            alive = 0;
            for (int i = 0; i < 4; i++) begin
                if (hand[i] > 21) bust[i] = 1'b1;
                if (!bust[i]) alive++;
            end
            if (alive < 2) break;
            mask = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
            press(mask);
            req = mask & ~bust;
            if (req == 4'd0) break;
            for (int i = 0; i < 4; i++) begin
                if (req[i]) begin
                    expect_deal(i, 1'b1, c);
                    hand[i] += c;
                end
            end
        end
        best = -1;
        win  = 0;
        cnt  = 0;
        for (int i = 0; i < 4; i++) begin
            if (!bust[i]) begin
                if (hand[i] > best) begin
                    best = hand[i];
                    win  = i;
                    cnt  = 1;
                end else if (hand[i] == best) begin
                    cnt++;
                end
            end
        end
        if (cnt == 1) expect_res(win, 0, best);
        else          expect_res(0, 1, 0);
        chk("sum_cap", int'(obs_sum > 21 && obs_tie == 0), 0);
    endtask

    initial begin
        repeat (3) @(negedge CLK);
        chk("rst_ov", obs_ov, 0);
        chk("rst_rv", obs_rv, 0);
        chk("rst_card", obs_card, 0);
        chk("rst_player", obs_player, 0);
        chk("rst_win", obs_win, 0);
        chk("rst_tie", obs_tie, 0);
        chk("rst_sum", obs_sum, 0);
        RESET = 1'b0;

        press(4'd0);
        deal3();
        chk("consecutive", t_last - t_prev, 1);
        @(negedge CLK);
        chk("hold_ov", obs_ov, 0);
        chk("hold_card", obs_card, 1);
        chk("hold_player", obs_player, 2);
        press(4'b000);
        expect_res(0, 1, 0);

        press(4'd0);
        deal3();
        press(4'b010);
        begin int c; expect_deal(1, 1'b0, c); end
        press(4'b000);
        expect_res(1, 0, 2);
        @(negedge CLK);
        chk("res_pulse", obs_rv, 0);
        chk("sum_hold", obs_sum, 2);

        press(4'd0);
        deal3();
        press(4'b101);
        begin int c; expect_deal(0, 1'b0, c); expect_deal(2, 1'b0, c); end
        press(4'b101);
        begin int c; expect_deal(0, 1'b0, c); expect_deal(2, 1'b0, c); end
        expect_res(1, 0, 1);

        press(4'd0);
        deal3();
        press(4'b011);
        begin int c; expect_deal(0, 1'b0, c); expect_deal(1, 1'b0, c); end
        press(4'b001);
        begin int c; expect_deal(0, 1'b0, c); end
        press(4'b001);
        expect_res(1, 0, 2);

        press(4'd0);
        begin int c; expect_deal(0, 1'b0, c); end
        RESET = 1'b1;
        @(negedge CLK);
        chk("abort_ov", obs_ov, 0);
        chk("abort_rv", obs_rv, 0);
        chk("abort_card", obs_card, 0);
        chk("abort_player", obs_player, 0);
        chk("abort_sum", obs_sum, 0);
        RESET = 1'b0;
        press(4'd0);
        deal3();
        press(4'b000);
        expect_res(0, 1, 0);

        sel = 1'b1;
        for (int g = 0; g < 500; g++) begin
            big_game();
            if (errs > 20) break;
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
